// File: rtl/pcie_ats_inval_pkg.sv
// Shared widths, constants and ingress FSM state type for the ATS invalidate tracker.
package pcie_ats_inval_pkg;

  localparam int unsigned ItagW      = 5;
  localparam int unsigned TableDepth = 32;
  localparam int unsigned RidW       = 16;
  localparam int unsigned OutW       = 6;
  localparam logic [2:0]  CplCc      = 3'd1;

  typedef enum logic {
    StIdle,
    StFwd
  } ingress_state_e;

endpackage

// File: rtl/pcie_ats_itag_table.sv
// ITag-indexed table of pending invalidates (valid + requester ID) with a live-entry counter.
module pcie_ats_itag_table
  import pcie_ats_inval_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [ItagW-1:0] set_itag,
  input  logic [RidW-1:0]  set_rid,
  input  logic             clr_en,
  input  logic [ItagW-1:0] clr_itag,
  input  logic [ItagW-1:0] req_itag,
  output logic             req_hit,
  input  logic [ItagW-1:0] ack_itag,
  output logic             ack_hit,
  output logic [RidW-1:0]  ack_rid,
  output logic [OutW-1:0]  outstanding
);

  logic [TableDepth-1:0] valid_q, valid_d;
  logic [RidW-1:0]       rid_q [TableDepth];
  logic [OutW-1:0]       count_q, count_d;

  assign req_hit     = valid_q[req_itag];
  assign ack_hit     = valid_q[ack_itag];
  assign ack_rid     = rid_q[ack_itag];
  assign outstanding = count_q;

  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_itag] = 1'b0;
    if (set_en) valid_d[set_itag] = 1'b1;
  end

  // Set and clear always target different ITags, so a simultaneous pair nets to zero.
  always_comb begin
    count_d = count_q;
    unique case ({set_en, clr_en})
      2'b10: if (count_q != OutW'(TableDepth)) count_d = count_q + 1'b1;
      2'b01: if (count_q != '0) count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (set_en) rid_q[set_itag] <= set_rid;
  end

endmodule

// File: rtl/pcie_ats_inval_tracker.sv
// ATS Invalidate Request tracker: forwards host invalidates to the AFU and returns completions.
// Optional watchdog enabled by defining OFS_ATS_INVAL_WATCHDOG_EN.
module pcie_ats_inval_tracker
  import pcie_ats_inval_pkg::*;
#(
  parameter int unsigned         NUM_PFS        = 8,
  parameter logic [NUM_PFS-1:0]  ATS_CAP_EN     = {NUM_PFS{1'b1}},
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv_req_valid,
  output logic             inv_req_ready,
  input  logic [2:0]       inv_req_pf,
  input  logic [ItagW-1:0] inv_req_itag,
  input  logic [RidW-1:0]  inv_req_rid,
  output logic             afu_inv_valid,
  input  logic             afu_inv_ready,
  output logic [ItagW-1:0] afu_inv_itag,
  input  logic             afu_ack_valid,
  output logic             afu_ack_ready,
  input  logic [ItagW-1:0] afu_ack_itag,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [RidW-1:0]  cpl_rid,
  output logic [31:0]      cpl_itag_vec,
  output logic [2:0]       cpl_cc,
  output logic [OutW-1:0]  outstanding,
  output logic             err_unsup,
  output logic             err_timeout
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  ingress_state_e   state_q, state_d;
  logic [ItagW-1:0] itag_q, itag_d;
  logic             unsup_q, unsup_d;
  logic             pf_supported;
  logic             req_hit, ack_hit, set_en, clr_en, ack_fire;
  logic [RidW-1:0]  ack_rid;
  logic             cpl_valid_q;
  logic [RidW-1:0]  cpl_rid_q;
  logic [31:0]      cpl_vec_q;

  always_comb begin
    pf_supported = 1'b0;
    for (int unsigned i = 0; i < NUM_PFS; i++) begin
      if (i == 32'(inv_req_pf)) pf_supported = |(ATS_CAP_EN & (NUM_PFS'(1) << i));
    end
  end

  always_comb begin
    state_d       = state_q;
    itag_d        = itag_q;
    unsup_d       = 1'b0;
    set_en        = 1'b0;
    inv_req_ready = 1'b0;
    afu_inv_valid = 1'b0;
    case (state_q)
      StIdle: begin
        // A live entry stalls a reused ITag, which lets a same-cycle ack win.
        inv_req_ready = !req_hit;
        if (inv_req_valid && !req_hit) begin
          if (pf_supported) begin
            set_en  = 1'b1;
            itag_d  = inv_req_itag;
            state_d = StFwd;
          end else begin
            unsup_d = 1'b1;
          end
        end
      end
      StFwd: begin
        afu_inv_valid = 1'b1;
        if (afu_inv_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      itag_q  <= '0;
      unsup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      itag_q  <= itag_d;
      unsup_q <= unsup_d;
    end
  end

  assign afu_inv_itag  = itag_q;
  assign err_unsup     = unsup_q;
  assign afu_ack_ready = !cpl_valid_q || cpl_ready;
  assign ack_fire      = afu_ack_valid && afu_ack_ready;
  assign clr_en        = ack_fire && ack_hit;

  pcie_ats_itag_table u_table (
    .clk         (clk),
    .rst         (rst),
    .set_en      (set_en),
    .set_itag    (inv_req_itag),
    .set_rid     (inv_req_rid),
    .clr_en      (clr_en),
    .clr_itag    (afu_ack_itag),
    .req_itag    (inv_req_itag),
    .req_hit     (req_hit),
    .ack_itag    (afu_ack_itag),
    .ack_hit     (ack_hit),
    .ack_rid     (ack_rid),
    .outstanding (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_valid_q <= 1'b0;
      cpl_rid_q   <= '0;
      cpl_vec_q   <= '0;
    end else if (clr_en) begin
      cpl_valid_q <= 1'b1;
      cpl_rid_q   <= ack_rid;
      cpl_vec_q   <= 32'(1) << afu_ack_itag;
    end else if (cpl_ready) begin
      cpl_valid_q <= 1'b0;
    end
  end

  assign cpl_valid    = cpl_valid_q;
  assign cpl_rid      = cpl_rid_q;
  assign cpl_itag_vec = cpl_vec_q;
  assign cpl_cc       = CplCc;

`ifdef OFS_ATS_INVAL_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (ack_fire || outstanding == '0) wd_cnt_d = '0;
    else if (wd_cnt_q != 16'hFFFF)     wd_cnt_d = wd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_q | (wd_cnt_d == 16'(TIMEOUT_CYCLES));
    end
  end

  assign err_timeout = timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
